// File: rtl/rr_arb_pkg.sv
// Package rr_arb_pkg
// Purpose : shared constants and types for the 16-way round-robin arbiter.
//   N_REQ        number of requesters (fixed at 16, matches a 4-to-16 decoder)
//   IDX_W        grant index width
//   MAX_HOLD_DEF default hold limit, used only when ARB_HOLD_TIMEOUT_EN is defined
//   arb_state_t  arbiter FSM state (IDLE / GRANT)
package rr_arb_pkg;

  localparam int N_REQ        = 16;
  localparam int IDX_W        = 4;
  localparam int MAX_HOLD_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage : rr_arb_pkg

// File: rtl/rr_pick_16.sv
// Module rr_pick_16
// Purpose : combinational circular first-one search over 16 requests,
//           starting at position ptr and wrapping 15 -> 0.
// Ports   :
//   req   [15:0] in  request vector
//   ptr   [3:0]  in  search start position (highest priority)
//   idx   [3:0]  out index of the first set request at or after ptr (circular)
//   found        out 1 when any request is set; idx is meaningless otherwise
module rr_pick_16
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] enc;

  // Rotate right by ptr: rot[0] is the requester at ptr, rot[1] at ptr+1, ...
  // The 4-bit index sum wraps mod 16 by construction.
  always_comb begin
    rot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req[IDX_W'(i) + ptr];
    end
  end

  // Fixed-priority encode, lowest bit wins (scan high to low, last hit sticks).
  always_comb begin
    enc = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        enc = IDX_W'(i);
      end
    end
  end

  // Undo the rotation; mod-16 wrap again comes from the 4-bit add.
  assign idx   = enc + ptr;
  assign found = |req;

endmodule : rr_pick_16

// File: rtl/rr_arbiter_16.sv
// Module rr_arbiter_16
// Purpose : round-robin arbiter over 16 requesters. Emits a registered grant
//           index and grant enable intended to drive a 4-to-16 decoder's
//           a[3:0]/en directly. At most one grant at a time, and at least one
//           idle cycle between consecutive grants so decoder outputs never
//           overlap.
// Ports   :
//   clk            in  rising-edge clock
//   rst            in  synchronous active-high reset
//   req     [15:0] in  request vector, req[i]=1 means requester i wants the resource
//   gnt_idx [3:0]  out registered index of the granted requester (decoder a)
//   gnt_en         out registered grant valid (decoder en)
//   busy           out 1 while the FSM is in GRANT (same as gnt_en); doubles as
//                      the observable FSM state
// Configuration:
//   ARB_HOLD_TIMEOUT_EN  when defined, a grant is force-released after MAX_HOLD
//                        consecutive cycles (parameter MAX_HOLD, 1..255). When
//                        undefined there is no hold counter and a grant lasts as
//                        long as its request stays high.
// Handshake: a requester raises req[i] and keeps it high for as long as it needs
//   the resource; it owns the resource on every cycle gnt_en=1 with gnt_idx=i,
//   and releases by dropping req[i]. The grant drops one cycle later.
module rr_arbiter_16
  import rr_arb_pkg::*;
`ifdef ARB_HOLD_TIMEOUT_EN
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
)
`endif
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_en,
  output logic             busy
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_en_q, gnt_en_d;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             release_now;

`ifdef ARB_HOLD_TIMEOUT_EN
  logic [7:0]       hold_q, hold_d;
`endif

  rr_pick_16 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Release when the holder drops its request, or (timeout build) when it has
  // held for MAX_HOLD cycles. The timeout release takes the same path, so the
  // pointer moves past the holder and it re-wins only if nobody else asks.
`ifdef ARB_HOLD_TIMEOUT_EN
  assign release_now = !req[gnt_idx_q] || (hold_q == 8'(MAX_HOLD));
`else
  assign release_now = !req[gnt_idx_q];
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_idx_d = gnt_idx_q;
    gnt_en_d  = gnt_en_q;
`ifdef ARB_HOLD_TIMEOUT_EN
    hold_d    = hold_q;
`endif
    case (state_q)
      IDLE: begin
        // gnt_idx keeps its last value when nothing is requested.
        if (pick_found) begin
          gnt_idx_d = pick_idx;
          gnt_en_d  = 1'b1;
          state_d   = GRANT;
`ifdef ARB_HOLD_TIMEOUT_EN
          hold_d    = 8'd1;
`endif
        end
      end
      GRANT: begin
        // Other requests are ignored while a grant is held; a new search only
        // happens in the following IDLE cycle, which also provides the dead cycle.
        if (release_now) begin
          gnt_en_d = 1'b0;
          ptr_d    = gnt_idx_q + IDX_W'(1);
          state_d  = IDLE;
        end
`ifdef ARB_HOLD_TIMEOUT_EN
        else if (hold_q != 8'hFF) begin
          hold_d = hold_q + 8'd1;
        end
`endif
      end
      default: begin
        state_d  = IDLE;
        gnt_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_idx_q <= '0;
      gnt_en_q  <= 1'b0;
`ifdef ARB_HOLD_TIMEOUT_EN
      hold_q    <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_en_q  <= gnt_en_d;
`ifdef ARB_HOLD_TIMEOUT_EN
      hold_q    <= hold_d;
`endif
    end
  end

  assign gnt_idx = gnt_idx_q;
  assign gnt_en  = gnt_en_q;
  assign busy    = (state_q == GRANT);

endmodule : rr_arbiter_16

// File: tb/tb_rr_arbiter_16.sv
// Testbench for rr_arbiter_16: directed scenarios with literal expectations,
// then randomized requests and occasional resets, all checked every cycle
// against a behavioural model (circular search over a request list).
module tb_rr_arbiter_16;

  localparam int TB_MAX_HOLD = 4;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic [3:0]  gnt_idx;
  logic        gnt_en;
  logic        busy;

  int n_cmp;
  int n_err;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ARB_HOLD_TIMEOUT_EN
  rr_arbiter_16 #(.MAX_HOLD(TB_MAX_HOLD)) dut (
`else
  rr_arbiter_16 dut (
`endif
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt_idx (gnt_idx),
    .gnt_en  (gnt_en),
    .busy    (busy)
  );

  // ---------------- behavioural model ----------------
  // Model state: who holds the resource (or nobody), where the next search
  // starts, and how long the current holder has held.
  logic   m_valid;
  logic   m_en;
  int     m_idx;
  int     m_ptr;
  int     m_hold;

  initial begin
    m_valid = 1'b0;
    m_en    = 1'b0;
    m_idx   = 0;
    m_ptr   = 0;
    m_hold  = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_en    = 1'b0;
      m_idx   = 0;
      m_ptr   = 0;
      m_hold  = 0;
    end else if (m_valid) begin
      if (!m_en) begin
        // Walk requesters ptr, ptr+1, ... wrapping; first one asking wins.
        for (int k = 0; k < 16; k++) begin
          if (!m_en && req[(m_ptr + k) % 16]) begin
            m_en   = 1'b1;
            m_idx  = (m_ptr + k) % 16;
            m_hold = 1;
          end
        end
      end else begin
        logic drop;
        drop = !req[m_idx];
`ifdef ARB_HOLD_TIMEOUT_EN
        if (m_hold >= TB_MAX_HOLD) drop = 1'b1;
`endif
        if (drop) begin
          m_en  = 1'b0;
          m_ptr = (m_idx + 1) % 16;
        end else begin
          m_hold = m_hold + 1;
        end
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_gnt_en", int'(gnt_en), int'(m_en));
      check("model_gnt_idx", int'(gnt_idx), m_idx);
      check("model_busy", int'(busy), int'(m_en));
    end
  end

  // ---------------- driver ----------------
  // Apply inputs just after an edge, then advance one edge; on return the
  // outputs reflect the edge that sampled these inputs.
  task automatic tick(input logic [15:0] r, input logic rs);
    req = r;
    rst = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick(16'h0000, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] r;
  int          order;
  int          low_run;
  logic        prev_en;
  bit          first_grant;

  initial begin
    n_cmp = 0;
    n_err = 0;
    req   = 16'hFFFF;
    rst   = 1'b1;
    @(posedge clk);
    #1;

    // 1: reset holds grants off even with every request up.
    tick(16'hFFFF, 1'b1);
    check("rst_en_a", int'(gnt_en), 0);
    check("rst_idx_a", int'(gnt_idx), 0);
    tick(16'hFFFF, 1'b1);
    check("rst_en_b", int'(gnt_en), 0);
    check("rst_idx_b", int'(gnt_idx), 0);
    tick(16'hFFFF, 1'b0);
    check("first_grant_en", int'(gnt_en), 1);
    check("first_grant_idx", int'(gnt_idx), 0);
    tick(16'h0000, 1'b0);
    check("first_release_en", int'(gnt_en), 0);

    // 2: single requester 5; release moves search start to 6.
    do_reset();
    tick(16'h0020, 1'b0);
    check("single_en", int'(gnt_en), 1);
    check("single_idx", int'(gnt_idx), 5);
    for (int i = 0; i < 3; i++) begin
      tick(16'h0020, 1'b0);
      check("single_hold", int'(gnt_en), 1);
    end
    tick(16'h0000, 1'b0);
    check("single_rel_en", int'(gnt_en), 0);
    check("single_rel_idx", int'(gnt_idx), 5);
    tick(16'h0061, 1'b0);
    check("ptr6_idx", int'(gnt_idx), 6);
    tick(16'h0000, 1'b0);

    // 3: wrap 0 -> 15 -> 0.
    do_reset();
    tick(16'h8001, 1'b0);
    check("wrap_g0", int'(gnt_idx), 0);
    tick(16'h8000, 1'b0);
    check("wrap_dead", int'(gnt_en), 0);
    tick(16'h8000, 1'b0);
    check("wrap_g15_en", int'(gnt_en), 1);
    check("wrap_g15", int'(gnt_idx), 15);
    tick(16'h0003, 1'b0);
    check("wrap_dead2", int'(gnt_en), 0);
    tick(16'h0003, 1'b0);
    check("wrap_g0_again", int'(gnt_idx), 0);
    tick(16'h0000, 1'b0);
    tick(16'h0000, 1'b0);

    // 4: full rotation, each requester drops after seeing its grant.
    do_reset();
    r           = 16'hFFFF;
    order       = 0;
    low_run     = 0;
    prev_en     = 1'b0;
    first_grant = 1'b1;
    for (int c = 0; c < 80 && order < 16; c++) begin
      tick(r, 1'b0);
      if (gnt_en && !prev_en) begin
        check("rot_order", int'(gnt_idx), order);
        if (!first_grant) check("rot_gap", low_run, 1);
        first_grant = 1'b0;
        order++;
        r[gnt_idx] = 1'b0;
      end
      low_run = gnt_en ? 0 : low_run + 1;
      prev_en = gnt_en;
    end
    check("rot_count", order, 16);
    tick(16'h0000, 1'b0);
    tick(16'h0000, 1'b0);

    // 5: long hold on requester 3 (timeout only in the macro build).
    do_reset();
`ifdef ARB_HOLD_TIMEOUT_EN
    for (int i = 0; i < TB_MAX_HOLD; i++) begin
      tick(16'h0008, 1'b0);
      check("to_hold_en", int'(gnt_en), 1);
      check("to_hold_idx", int'(gnt_idx), 3);
    end
    tick(16'h0008, 1'b0);
    check("to_dead", int'(gnt_en), 0);
    tick(16'h0008, 1'b0);
    check("to_regrant_en", int'(gnt_en), 1);
    check("to_regrant_idx", int'(gnt_idx), 3);
    do_reset();
    for (int i = 0; i < TB_MAX_HOLD; i++) begin
      tick(16'h0018, 1'b0);
      check("to2_hold_idx", int'(gnt_idx), 3);
    end
    tick(16'h0018, 1'b0);
    check("to2_dead", int'(gnt_en), 0);
    tick(16'h0018, 1'b0);
    check("to2_next_idx", int'(gnt_idx), 4);
`else
    for (int i = 0; i < 20; i++) begin
      tick(16'h0018, 1'b0);
      check("hold_forever_en", int'(gnt_en), 1);
      check("hold_forever_idx", int'(gnt_idx), 3);
    end
`endif
    tick(16'h0000, 1'b0);

    // 6: reset mid-grant clears pointer; 2 beats 9 afterwards.
    do_reset();
    tick(16'h0200, 1'b0);
    check("mid_g9", int'(gnt_idx), 9);
    tick(16'h0200, 1'b1);
    check("mid_rst_en", int'(gnt_en), 0);
    check("mid_rst_idx", int'(gnt_idx), 0);
    tick(16'h0204, 1'b0);
    check("mid_after_idx", int'(gnt_idx), 2);
    tick(16'h0000, 1'b0);

    // Random traffic: sticky requests with sparse toggles and rare resets.
    r = 16'h0000;
    for (int c = 0; c < 3000; c++) begin
      r = r ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      tick(r, ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_rr_arbiter_16
